btc_nonce_scheduler: RTL
========================

# btc_nonce_scheduler

Sequencing controller between the Wishbone register file and the SHA-256d hashing core inside `btc_miner_top`. Firmware loads a nonce range and a 256-bit target, then pulses start. The block issues one nonce per core job, checks each returned hash against the target, and stops on the first winning nonce or at range exhaustion. It reports through status outputs and a one-cycle interrupt pulse.

## Interface
Parameters:
- `NONCE_W`, 32: nonce width.
- `HASH_W`, 256: digest and target width.

Ports:
- `wb_clk_i`  in  1  system clock; all logic on the rising edge.
- `wb_rst_n_i`  in  1  asynchronous active-low reset.
- `start_i`  in  1  one-cycle pulse from the register file; begins a job.
- `stop_i`  in  1  one-cycle pulse; abort request.
- `nonce_start_i`  in  NONCE_W  first nonce, inclusive.
- `nonce_end_i`  in  NONCE_W  last nonce, inclusive.
- `target_i`  in  HASH_W  a hash is a win when it is <= target (unsigned).
- `core_ready_i`  in  1  core can accept a job.
- `core_start_o`  out  1  job request, held until accepted.
- `core_nonce_o`  out  NONCE_W  nonce for the current job.
- `core_done_i`  in  1  one-cycle pulse; `core_hash_i` is valid.
- `core_hash_i`  in  HASH_W  final digest.
- `busy_o`  out  1  job in progress.
- `found_o`  out  1  sticky; a win was found.
- `golden_nonce_o`  out  NONCE_W  winning nonce.
- `hash_count_o`  out  NONCE_W  hashes checked in the current job.
- `done_o`  out  1  sticky; the last job ended (win, exhaustion or abort).
- `irq_o`  out  1  one-cycle pulse when a job ends.

## Operation
The state machine has states IDLE, ISSUE, WAIT, CHECK and DRAIN.

- **IDLE**
  - On `start_i`, latch `nonce_start_i`, `nonce_end_i` and `target_i` into internal registers.
  - Clear `found_o`, `done_o`, `hash_count_o` and `golden_nonce_o`.
  - Go to ISSUE.
  - `stop_i` is ignored in IDLE.
- **ISSUE**
  - Assert `core_start_o` with `core_nonce_o` set to the current nonce.
  - The job is accepted in a cycle where both `core_start_o` and `core_ready_i` are high; then go to WAIT.
- **WAIT**
  - On `core_done_i`, register `core_hash_i` and go to CHECK.
- **CHECK**
  - Increment `hash_count_o`. It saturates at all-ones.
  - On a win (hash <= latched target): set `golden_nonce_o` to the current nonce, set `found_o` and `done_o`, pulse `irq_o`, go to IDLE.
  - Otherwise, if nonce == latched end: set `done_o`, pulse `irq_o`, go to IDLE. `found_o` stays 0.
  - Otherwise: increment nonce and go to ISSUE.
- **Abort (`stop_i`)**
  - In ISSUE before acceptance: drop `core_start_o` and go to IDLE at once, setting `done_o` and pulsing `irq_o`.
  - In WAIT: go to DRAIN.
  - In CHECK: the CHECK outcome is taken; a pending stop is then honoured as an abort without issuing again.
- **DRAIN**
  - Wait for `core_done_i`, discard the hash, set `done_o`, pulse `irq_o`, go to IDLE.
- **Range rules**
  - Nonce arithmetic is modulo 2^NONCE_W.
  - If start > end, the range wraps through all-ones to 0 and ends at end.
  - start == end gives exactly one hash.
  - The full range (start = end + 1) gives 2^NONCE_W hashes.
- **Simultaneous events**
  - `start_i` and `stop_i` together in IDLE: start wins.
  - `start_i` while busy is ignored.
- `busy_o` = (state != IDLE).

## Timing
- **Reset values**: every output is 0; state is IDLE; internal registers are 0.
- An asynchronous reset mid-job returns to IDLE immediately with no `irq_o` pulse. The core is reset by the same net.
- **Handshake**:
  - `core_start_o` rises in the cycle after `start_i`.
  - `core_start_o` and `core_nonce_o` stay stable until accepted and fall in the cycle after acceptance.
- **Per-nonce overhead**: 2 cycles beyond core latency (ISSUE and CHECK), assuming `core_ready_i` is high.
- **Status after a job ends**:
  - `irq_o` is high for exactly the cycle in which the state returns to IDLE.
  - `done_o` and `found_o` are valid in that same cycle and hold until the next accepted `start_i`.
- `core_done_i` is ignored outside WAIT and DRAIN.

## Structure
- Shared package `btc_miner_pkg` holds:
  - the state enum `sched_state_t` (IDLE, ISSUE, WAIT, CHECK, DRAIN);
  - the `NONCE_W` and `HASH_W` constants.
- One natural sub-module, `hash_le_cmp`: a registered 256-bit unsigned `<=` comparator.
  - It may be split into 8 x 32-bit slices for timing, but must still deliver its result within the CHECK cycle from the registered hash.
- Everything else stays in this module.

## Test plan
Each scenario checks the required response for the given stimulus; the model core returns a chosen hash 20 cycles after acceptance.

- **Win:** range 0x10..0x1F, target 0x0000FFFF..FF, hash below target only for nonce 0x13 → 4 jobs issued, `found_o`=1, `golden_nonce_o`=0x13, `hash_count_o`=4, one `irq_o` pulse.
- **Exhaustion:** range 0x5..0x5, hash all-ones, target 0 → exactly 1 job, `done_o`=1, `found_o`=0, `hash_count_o`=1.
- **Wrap:** range 0xFFFFFFFE..0x1, no win → nonces issued in order FFFFFFFE, FFFFFFFF, 0, 1; `hash_count_o`=4.
- **Backpressure and equality:**
  - Hold `core_ready_i` low for 7 cycles: `core_start_o` and `core_nonce_o` stay stable and exactly one job is accepted.
  - A hash equal to the target counts as a win.
- **Abort:** `stop_i` 5 cycles into WAIT → no further `core_start_o`; after `core_done_i`, `done_o`=1 and `found_o`=0. A `start_i` while busy has no effect.
- **Reset:** `wb_rst_n_i` low mid-WAIT → all outputs 0 asynchronously and no `irq_o` pulse; a new job then runs normally.

Source files
------------

// File: rtl/btc_miner_pkg.sv
// Shared types and widths for the miner datapath.
// Nonce scheduler states live here too.
package btc_miner_pkg;

  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DRAIN
  } sched_state_t;

endpackage

// File: rtl/btc_nonce_scheduler_hash_le_cmp.sv
// Registered unsigned hash <= target compare.
// Hash is captured on load; result is combinational from the register.
module hash_le_cmp
  import btc_miner_pkg::*;
#(
  parameter int W  = HASH_W,
  parameter int SW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] hash_i,
  input  logic [W-1:0] target_i,
  output logic         le_o
);

  localparam int NS = W / SW;

  logic [W-1:0]  hash_q;
  logic [NS-1:0] gt;
  logic [NS-1:0] eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q <= '0;
    end else if (load) begin
      hash_q <= hash_i;
    end
  end

  always_comb begin
    gt = '0;
    eq = '0;
    for (int i = 0; i < NS; i++) begin
      gt[i] = hash_q[i*SW +: SW] > target_i[i*SW +: SW];
      eq[i] = hash_q[i*SW +: SW] == target_i[i*SW +: SW];
    end
  end

  // Higher slices override lower ones; all-equal means <=.
  always_comb begin
    le_o = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (gt[i]) begin
        le_o = 1'b0;
      end else if (!eq[i]) begin
        le_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btc_nonce_scheduler.sv
// Nonce scheduler: issues one nonce per core job and checks
// each digest against the latched target.
module btc_nonce_scheduler
  import btc_miner_pkg::*;
#(
  parameter int NONCE_W = btc_miner_pkg::NONCE_W,
  parameter int HASH_W  = btc_miner_pkg::HASH_W
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [NONCE_W-1:0] nonce_start_i,
  input  logic [NONCE_W-1:0] nonce_end_i,
  input  logic [HASH_W-1:0]  target_i,
  input  logic               core_ready_i,
  output logic               core_start_o,
  output logic [NONCE_W-1:0] core_nonce_o,
  input  logic               core_done_i,
  input  logic [HASH_W-1:0]  core_hash_i,
  output logic               busy_o,
  output logic               found_o,
  output logic [NONCE_W-1:0] golden_nonce_o,
  output logic [NONCE_W-1:0] hash_count_o,
  output logic               done_o,
  output logic               irq_o
);

  sched_state_t state_q;
  sched_state_t state_d;

  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] end_q;
  logic [HASH_W-1:0]  target_q;
  logic [NONCE_W-1:0] count_q;
  logic [NONCE_W-1:0] golden_q;
  logic               found_q;
  logic               done_q;
  logic               irq_q;

  logic ld_job;
  logic ld_hash;
  logic chk;
  logic win;
  logic adv;
  logic fin;
  logic le;

  hash_le_cmp #(
    .W  (HASH_W),
    .SW (32)
  ) u_cmp (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .load     (ld_hash),
    .hash_i   (core_hash_i),
    .target_i (target_q),
    .le_o     (le)
  );

  always_comb begin
    state_d = state_q;
    ld_job  = 1'b0;
    ld_hash = 1'b0;
    chk     = 1'b0;
    win     = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ld_job  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An accepted job must be drained even if aborted.
        if (core_ready_i) begin
          state_d = stop_i ? DRAIN : WAIT;
        end else if (stop_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (core_done_i && stop_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (core_done_i) begin
          ld_hash = 1'b1;
          state_d = CHECK;
        end else if (stop_i) begin
          state_d = DRAIN;
        end
      end
      CHECK: begin
        chk = 1'b1;
        if (le) begin
          win     = 1'b1;
          fin     = 1'b1;
          state_d = IDLE;
        end else if (nonce_q == end_q || stop_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else begin
          adv     = 1'b1;
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (core_done_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      nonce_q  <= '0;
      end_q    <= '0;
      target_q <= '0;
      count_q  <= '0;
      golden_q <= '0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= fin;
      if (ld_job) begin
        nonce_q  <= nonce_start_i;
        end_q    <= nonce_end_i;
        target_q <= target_i;
        count_q  <= '0;
        golden_q <= '0;
        found_q  <= 1'b0;
        done_q   <= 1'b0;
      end
      if (adv) begin
        nonce_q <= nonce_q + NONCE_W'(1);
      end
      if (chk && count_q != '1) begin
        count_q <= count_q + NONCE_W'(1);
      end
      if (win) begin
        golden_q <= nonce_q;
        found_q  <= 1'b1;
      end
      if (fin) begin
        done_q <= 1'b1;
      end
    end
  end

  assign core_start_o   = (state_q == ISSUE);
  assign core_nonce_o   = nonce_q;
  assign busy_o         = (state_q != IDLE);
  assign found_o        = found_q;
  assign golden_nonce_o = golden_q;
  assign hash_count_o   = count_q;
  assign done_o         = done_q;
  assign irq_o          = irq_q;

endmodule
